fetch_ref_luma_nbank: RTL and testbench

Parametrised N-bank ping-pong reference-luma buffer feeding FIME and FME. External loads fill one bank while FIME and FME read the two most recently completed banks; the roles rotate on each sysif_start_i. It adds per-bank valid tracking, a registered and flagged read path, out-of-range write protection and parametrised search-window clamping. It sits between the external fetch/DMA engine and the FIME/FME engines.

---
 rtl/fetch_ref_luma_nbank_pkg.sv | 25 ++
 rtl/fetch_ref_luma_nbank_ram.sv | 27 ++
 rtl/fetch_ref_luma_nbank.sv | 193 +++++++++++++++++++
 tb/tb_fetch_ref_luma_nbank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ref_luma_nbank_pkg.sv
// Shared constants for the N-bank reference-luma buffer: bank index type,
// role offsets relative to the write pointer, and error flag positions.
package fetch_ref_luma_nbank_pkg;

    // Index width covers the largest legal bank count (8).
    localparam int MAX_BANK   = 8;
    localparam int BANK_IDX_W = $clog2(MAX_BANK);

    localparam int FIME_ROLE_OFF = 1;
    localparam int FME_ROLE_OFF  = 2;

    localparam int ERR_RD_INVALID = 0;
    localparam int ERR_WR_RANGE   = 1;

    typedef logic [BANK_IDX_W-1:0] bank_idx_t;

    // (ptr - off) mod num_bank without a divider.
    function automatic bank_idx_t role_bank(input bank_idx_t ptr, input int off, input int num_bank);
        int p;
        p = int'(ptr) - off;
        if (p < 0) p = p + num_bank;
        return bank_idx_t'(p);
    endfunction

endpackage

// File: rtl/fetch_ref_luma_nbank_ram.sv
// One row bank: DEPTH x WIDTH simple dual-port RAM, registered read output
// that holds its value when no read is requested.
module fetch_ref_bank_ram #(
    parameter  int DEPTH  = 80,
    parameter  int WIDTH  = 768,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fetch_ref_luma_nbank.sv
// Rotating N-bank reference-luma buffer: one bank is loaded while FIME and FME
// read the two most recently completed banks through a 2-cycle registered path.
module fetch_ref_luma_nbank
    import fetch_ref_luma_nbank_pkg::*;
#(
    parameter  int NUM_BANK     = 3,
    parameter  int PIXEL_WIDTH  = 8,
    parameter  int ROW_PEL      = 96,
    parameter  int OUT_PEL      = 64,
    parameter  int DEPTH        = 80,
    parameter  int PIC_Y_W      = 9,
    parameter  int FIME_WIN_OFF = 28,
    parameter  int FME_WIN_OFF  = 32,
    parameter  int FIME_TOP_OFF = 12,
    parameter  int FIME_Y_OFF   = 4,
    parameter  int FME_TOP_OFF  = 16,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int ROW_W        = ROW_PEL * PIXEL_WIDTH,
    localparam int OUT_W        = OUT_PEL * PIXEL_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sysif_start_i,
    input  logic [PIC_Y_W-1:0] sysif_total_y_i,
    input  logic               ext_load_valid_i,
    input  logic [ADDR_W-1:0]  ext_load_addr_i,
    input  logic [ROW_W-1:0]   ext_load_data_i,
    input  logic               ext_load_done_i,
    input  logic [PIC_Y_W-1:0] fime_cur_y_i,
    input  logic               fime_ref_rden_i,
    input  logic [7:0]         fime_ref_x_i,
    input  logic [7:0]         fime_ref_y_i,
    output logic [OUT_W-1:0]   fime_ref_pel_o,
    output logic               fime_ref_vld_o,
    input  logic [PIC_Y_W-1:0] fme_cur_y_i,
    input  logic               fme_ref_rden_i,
    input  logic [6:0]         fme_ref_x_i,
    input  logic [6:0]         fme_ref_y_i,
    output logic [OUT_W-1:0]   fme_ref_pel_o,
    output logic               fme_ref_vld_o,
    output logic [NUM_BANK-1:0] bank_valid_o,
    output logic [1:0]         err_o
);

    bank_idx_t wr_ptr_q, wr_ptr_d, wr_next;
    bank_idx_t fime_bank, fme_bank;
    logic [NUM_BANK-1:0] bank_valid_q, bank_valid_d;
    logic [1:0] err_q, err_d;
    logic wr_ok, fime_bank_ok, fme_bank_ok;
    logic [ADDR_W-1:0] fime_row, fme_row;

    logic [NUM_BANK-1:0] ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_raddr [NUM_BANK];
    logic [ROW_W-1:0]    ram_rdata [NUM_BANK];

    bank_idx_t fime_bank_s1_q, fime_bank_s1_d, fme_bank_s1_q, fme_bank_s1_d;
    logic [7:0] fime_x_s1_q, fime_x_s1_d;
    logic [6:0] fme_x_s1_q, fme_x_s1_d;
    logic fime_rden_s1_q, fime_rden_s1_d, fme_rden_s1_q, fme_rden_s1_d;

    logic [ROW_W-1:0] fime_rdata, fme_rdata, fime_shift, fme_shift;
    logic [OUT_W-1:0] fime_pel_q, fime_pel_d, fme_pel_q, fme_pel_d;
    logic fime_vld_q, fime_vld_d, fme_vld_q, fme_vld_d;

    function automatic logic [ADDR_W-1:0] clamp_row(input int row);
        return (row > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : ADDR_W'(row);
    endfunction

    // Top picture row pulls the window up; the top case wins when total_y is 0.
    function automatic logic [ADDR_W-1:0] row_sel(input logic [PIC_Y_W-1:0] cur_y,
                                                  input logic [PIC_Y_W-1:0] total_y,
                                                  input int y, input int top_off,
                                                  input int y_off);
        int row;
        if (cur_y == '0)
            row = (y < top_off) ? 0 : y - top_off;
        else if (cur_y == total_y)
            row = (y + y_off > DEPTH - 1) ? DEPTH - 1 : y + y_off;
        else
            row = y + y_off;
        return clamp_row(row);
    endfunction

    assign fime_row = row_sel(fime_cur_y_i, sysif_total_y_i, int'(fime_ref_y_i),
                              FIME_TOP_OFF, FIME_Y_OFF);
    assign fme_row  = row_sel(fme_cur_y_i, sysif_total_y_i, int'(fme_ref_y_i),
                              FME_TOP_OFF, 0);

    always_comb begin
        wr_next      = (wr_ptr_q == bank_idx_t'(NUM_BANK - 1)) ? '0 : wr_ptr_q + 1'b1;
        wr_ptr_d     = sysif_start_i ? wr_next : wr_ptr_q;
        fime_bank    = role_bank(wr_ptr_q, FIME_ROLE_OFF, NUM_BANK);
        fme_bank     = role_bank(wr_ptr_q, FME_ROLE_OFF, NUM_BANK);
        wr_ok        = ext_load_valid_i && (int'(ext_load_addr_i) < DEPTH);
        bank_valid_d = bank_valid_q;
        ram_we       = '0;
        ram_re       = '0;
        fime_bank_ok = 1'b0;
        fme_bank_ok  = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            ram_raddr[b] = (fime_bank == bank_idx_t'(b)) ? fime_row : fme_row;
            ram_we[b]    = wr_ok && (wr_ptr_q == bank_idx_t'(b));
            ram_re[b]    = (fime_ref_rden_i && (fime_bank == bank_idx_t'(b))) ||
                           (fme_ref_rden_i && (fme_bank == bank_idx_t'(b)));
            if (fime_bank == bank_idx_t'(b)) fime_bank_ok = bank_valid_q[b];
            if (fme_bank == bank_idx_t'(b))  fme_bank_ok  = bank_valid_q[b];
            // Clearing the incoming write bank overrides a same-edge done.
            if (ext_load_done_i && (wr_ptr_q == bank_idx_t'(b))) bank_valid_d[b] = 1'b1;
            if (sysif_start_i && (wr_next == bank_idx_t'(b)))    bank_valid_d[b] = 1'b0;
        end
        err_d = err_q;
        if (ext_load_valid_i && !wr_ok) err_d[ERR_WR_RANGE] = 1'b1;
        if ((fime_ref_rden_i && !fime_bank_ok) || (fme_ref_rden_i && !fme_bank_ok))
            err_d[ERR_RD_INVALID] = 1'b1;
    end

    // Bank and shift are captured with the request so a rotation in flight is harmless.
    always_comb begin
        fime_bank_s1_d = fime_ref_rden_i ? fime_bank : fime_bank_s1_q;
        fme_bank_s1_d  = fme_ref_rden_i ? fme_bank : fme_bank_s1_q;
        fime_x_s1_d    = fime_ref_rden_i ? fime_ref_x_i : fime_x_s1_q;
        fme_x_s1_d     = fme_ref_rden_i ? fme_ref_x_i : fme_x_s1_q;
        fime_rden_s1_d = fime_ref_rden_i;
        fme_rden_s1_d  = fme_ref_rden_i;
        fime_rdata     = '0;
        fme_rdata      = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (fime_bank_s1_q == bank_idx_t'(b)) fime_rdata = ram_rdata[b];
            if (fme_bank_s1_q == bank_idx_t'(b))  fme_rdata  = ram_rdata[b];
        end
        fime_shift = fime_rdata << (int'(fime_x_s1_q) * PIXEL_WIDTH);
        fme_shift  = fme_rdata << (int'(fme_x_s1_q) * PIXEL_WIDTH);
        fime_pel_d = fime_rden_s1_q ? OUT_W'(fime_shift >> (FIME_WIN_OFF * PIXEL_WIDTH)) : fime_pel_q;
        fme_pel_d  = fme_rden_s1_q ? OUT_W'(fme_shift >> (FME_WIN_OFF * PIXEL_WIDTH)) : fme_pel_q;
        fime_vld_d = fime_rden_s1_q;
        fme_vld_d  = fme_rden_s1_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q       <= '0;
            bank_valid_q   <= '0;
            err_q          <= '0;
            fime_bank_s1_q <= '0;
            fme_bank_s1_q  <= '0;
            fime_x_s1_q    <= '0;
            fme_x_s1_q     <= '0;
            fime_rden_s1_q <= 1'b0;
            fme_rden_s1_q  <= 1'b0;
            fime_pel_q     <= '0;
            fme_pel_q      <= '0;
            fime_vld_q     <= 1'b0;
            fme_vld_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            bank_valid_q   <= bank_valid_d;
            err_q          <= err_d;
            fime_bank_s1_q <= fime_bank_s1_d;
            fme_bank_s1_q  <= fme_bank_s1_d;
            fime_x_s1_q    <= fime_x_s1_d;
            fme_x_s1_q     <= fme_x_s1_d;
            fime_rden_s1_q <= fime_rden_s1_d;
            fme_rden_s1_q  <= fme_rden_s1_d;
            fime_pel_q     <= fime_pel_d;
            fme_pel_q      <= fme_pel_d;
            fime_vld_q     <= fime_vld_d;
            fme_vld_q      <= fme_vld_d;
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        fetch_ref_bank_ram #(
            .DEPTH (DEPTH),
            .WIDTH (ROW_W)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[b]),
            .waddr (ext_load_addr_i),
            .wdata (ext_load_data_i),
            .re    (ram_re[b]),
            .raddr (ram_raddr[b]),
            .rdata (ram_rdata[b])
        );
    end

    assign fime_ref_pel_o = fime_pel_q;
    assign fime_ref_vld_o = fime_vld_q;
    assign fme_ref_pel_o  = fme_pel_q;
    assign fme_ref_vld_o  = fme_vld_q;
    assign bank_valid_o   = bank_valid_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_fetch_ref_luma_nbank.sv
// Bench for fetch_ref_luma_nbank: a 3-bank instance carries the data path
// scoreboard, a 5-bank instance covers pointer wrap and invalid-bank reads.
module tb_fetch_ref_luma_nbank;

    localparam int PW = 8, ROW_PEL = 96, OUT_PEL = 64, DEPTH = 80;
    localparam int ROW_W = ROW_PEL * PW, OUT_W = OUT_PEL * PW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             start3 = 0, start5 = 0, valid3 = 0, valid5 = 0, done3 = 0, done5 = 0;
    logic [8:0]       total_y = 0, fime_cur = 0, fme_cur = 0;
    logic [6:0]       ld_addr = 0;
    logic [ROW_W-1:0] ld_data = '0;
    logic             fime_rden3 = 0, fme_rden3 = 0, fime_rden5 = 0, fme_rden5 = 0;
    logic [7:0]       fime_x = 0, fime_y = 0;
    logic [6:0]       fme_x = 0, fme_y = 0;

    logic [OUT_W-1:0] fime_pel3, fme_pel3, fime_pel5, fme_pel5;
    logic             fime_vld3, fme_vld3, fime_vld5, fme_vld5;
    logic [2:0]       bank_valid3;
    logic [4:0]       bank_valid5;
    logic [1:0]       err3, err5;

    fetch_ref_luma_nbank u_dut3 (
        .clk(clk), .rstn(rstn), .sysif_start_i(start3), .sysif_total_y_i(total_y),
        .ext_load_valid_i(valid3), .ext_load_addr_i(ld_addr), .ext_load_data_i(ld_data),
        .ext_load_done_i(done3), .fime_cur_y_i(fime_cur), .fime_ref_rden_i(fime_rden3),
        .fime_ref_x_i(fime_x), .fime_ref_y_i(fime_y), .fime_ref_pel_o(fime_pel3),
        .fime_ref_vld_o(fime_vld3), .fme_cur_y_i(fme_cur), .fme_ref_rden_i(fme_rden3),
        .fme_ref_x_i(fme_x), .fme_ref_y_i(fme_y), .fme_ref_pel_o(fme_pel3),
        .fme_ref_vld_o(fme_vld3), .bank_valid_o(bank_valid3), .err_o(err3)
    );

    fetch_ref_luma_nbank #(.NUM_BANK(5)) u_dut5 (
        .clk(clk), .rstn(rstn), .sysif_start_i(start5), .sysif_total_y_i(total_y),
        .ext_load_valid_i(valid5), .ext_load_addr_i(ld_addr), .ext_load_data_i(ld_data),
        .ext_load_done_i(done5), .fime_cur_y_i(fime_cur), .fime_ref_rden_i(fime_rden5),
        .fime_ref_x_i(fime_x), .fime_ref_y_i(fime_y), .fime_ref_pel_o(fime_pel5),
        .fime_ref_vld_o(fime_vld5), .fme_cur_y_i(fme_cur), .fme_ref_rden_i(fme_rden5),
        .fme_ref_x_i(fme_x), .fme_ref_y_i(fme_y), .fme_ref_pel_o(fme_pel5),
        .fme_ref_vld_o(fme_vld5), .bank_valid_o(bank_valid5), .err_o(err5)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [OUT_W-1:0] exp_fime_q[$], exp_fme_q[$];
    int               due_fime_q[$], due_fme_q[$];
    logic [OUT_W-1:0] last_fime_exp = '0;
    logic [OUT_W-1:0] mon_e;
    int               mon_d;

    // Stored pel p of row r in the bank loaded as b.
    function automatic logic [7:0] pat(input int b, input int r, input int p);
        return 8'((r + 7 * p + 85 * b) % 256);
    endfunction

    function automatic logic [ROW_W-1:0] row_vec(input int b, input int r);
        logic [ROW_W-1:0] v;
        for (int p = 0; p < ROW_PEL; p++) v[p*PW +: PW] = pat(b, r, p);
        return v;
    endfunction

    // Output pel j is stored pel (off + j - x), zero where that falls outside the row.
    function automatic logic [OUT_W-1:0] exp_win(input int b, input int row, input int x, input int off);
        logic [OUT_W-1:0] v;
        int src;
        v = '0;
        for (int j = 0; j < OUT_PEL; j++) begin
            src = off + j - x;
            if (src >= 0 && src < ROW_PEL) v[j*PW +: PW] = pat(b, row, src);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start3 = 0; start5 = 0; valid3 = 0; done3 = 0; done5 = 0;
        fime_rden3 = 0; fme_rden3 = 0; fime_rden5 = 0;
    endtask

    task automatic fime_rd(input int cur, input int y, input int x, input int bank, input int row);
        fime_cur = 9'(cur); fime_y = 8'(y); fime_x = 8'(x); fime_rden3 = 1'b1;
        last_fime_exp = exp_win(bank, row, x, 28);
        exp_fime_q.push_back(last_fime_exp);
        due_fime_q.push_back(cyc + 2);
    endtask

    task automatic fme_rd(input int cur, input int y, input int x, input int bank, input int row);
        fme_cur = 9'(cur); fme_y = 7'(y); fme_x = 7'(x); fme_rden3 = 1'b1;
        exp_fme_q.push_back(exp_win(bank, row, x, 32));
        due_fme_q.push_back(cyc + 2);
    endtask

    task automatic load_bank(input int b);
        for (int r = 0; r < DEPTH; r++) begin
            valid3 = 1'b1; ld_addr = 7'(r); ld_data = row_vec(b, r);
            tick();
        end
    endtask

    // Monitor: pops one expectation per valid beat and checks data and arrival cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (fime_vld3) begin
                checks++;
                if (exp_fime_q.size() == 0) begin
                    errors++;
                    $display("FAIL fime_unexpected_vld: vld=1 at cycle %0d, none pending", cyc);
                end else begin
                    mon_e = exp_fime_q.pop_front(); mon_d = due_fime_q.pop_front();
                    if (fime_pel3 !== mon_e || cyc != mon_d) begin
                        errors++;
                        $display("FAIL fime_data: cycle %0d got %h, expected cycle %0d data %h", cyc, fime_pel3, mon_d, mon_e);
                    end
                end
            end else if (due_fime_q.size() != 0 && due_fime_q[0] <= cyc) begin
                checks++; errors++;
                $display("FAIL fime_missing_vld: vld=0 at cycle %0d, required 1", cyc);
                void'(exp_fime_q.pop_front()); void'(due_fime_q.pop_front());
            end
            if (fme_vld3) begin
                checks++;
                if (exp_fme_q.size() == 0) begin
                    errors++;
                    $display("FAIL fme_unexpected_vld: vld=1 at cycle %0d, none pending", cyc);
                end else begin
                    mon_e = exp_fme_q.pop_front(); mon_d = due_fme_q.pop_front();
                    if (fme_pel3 !== mon_e || cyc != mon_d) begin
                        errors++;
                        $display("FAIL fme_data: cycle %0d got %h, expected cycle %0d data %h", cyc, fme_pel3, mon_d, mon_e);
                    end
                end
            end else if (due_fme_q.size() != 0 && due_fme_q[0] <= cyc) begin
                checks++; errors++;
                $display("FAIL fme_missing_vld: vld=0 at cycle %0d, required 1", cyc);
                void'(exp_fme_q.pop_front()); void'(due_fme_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fime_vld", 64'(fime_vld3), 0);
        check("rst_fme_vld", 64'(fme_vld3), 0);
        check("rst_fime_pel_nonzero", 64'(|fime_pel3), 0);
        check("rst_fme_pel_nonzero", 64'(|fme_pel3), 0);
        check("rst_fime_pel5_nonzero", 64'(|fime_pel5), 0);
        check("rst_bank_valid3", 64'(bank_valid3), 0);
        check("rst_err3", 64'(err3), 0);
        check("rst_bank_valid5", 64'(bank_valid5), 0);
        rstn = 1'b1;
        tick();

        total_y = 9'd7;
        load_bank(0);
        done3 = 1; tick();
        check("valid_after_done0", 64'(bank_valid3), 64'b001);
        start3 = 1; tick();
        check("valid_after_start1", 64'(bank_valid3), 64'b001);
        load_bank(1);
        done3 = 1; tick();
        check("valid_after_done1", 64'(bank_valid3), 64'b011);
        start3 = 1; tick();
        load_bank(2);

        // wr_ptr=2: FIME reads bank1, FME reads bank0
        fime_rd(5, 10, 0, 1, 14); fme_rd(5, 10, 0, 0, 10); tick();
        // done+start together, with a FIME read in flight across the rotation
        done3 = 1; start3 = 1; fime_rd(5, 20, 0, 1, 24); tick();
        check("done_start_same_edge", 64'(bank_valid3), 64'b110);

        // wr_ptr=0: FIME reads bank2, FME reads bank1
        fime_rd(0, 5, 0, 2, 0);   fme_rd(0, 40, 0, 1, 24); tick();
        fime_rd(0, 20, 0, 2, 8);  fme_rd(0, 10, 0, 1, 0);  tick();
        fime_rd(7, 77, 0, 2, 79); fme_rd(7, 80, 0, 1, 79); tick();
        fime_rd(7, 60, 0, 2, 64); fme_rd(3, 50, 0, 1, 50); tick();
        fime_rd(3, 100, 0, 2, 79); tick();
        fime_rd(5, 30, 3, 2, 34); fme_rd(5, 30, 0, 1, 30); tick();
        fime_rd(5, 31, 40, 2, 35); fme_rd(5, 31, 5, 1, 31); tick();
        repeat (4) tick();
        checks++;
        if (fime_pel3 !== last_fime_exp) begin
            errors++;
            $display("FAIL fime_pel_hold: got %h expected %h", fime_pel3, last_fime_exp);
        end
        check("err_clean", 64'(err3), 0);

        valid3 = 1; ld_addr = 7'd85; ld_data = row_vec(3, 85); tick();
        check("err_wr_range", 64'(err3), 64'b10);

        start3 = 1; tick();
        check("valid_after_start_to1", 64'(bank_valid3), 64'b100);
        // wr_ptr=1: FIME bank0 (invalid, old data kept), FME bank2
        fime_rd(5, 10, 0, 0, 14); fme_rd(5, 10, 0, 2, 10); tick();
        check("err_rd_invalid", 64'(err3), 64'b11);
        repeat (3) tick();

        start5 = 1; tick();
        start5 = 1; tick();
        done5 = 1; tick();
        check("nb5_valid_at_ptr2", 64'(bank_valid5), 64'b00100);
        repeat (3) begin start5 = 1; tick(); end
        done5 = 1; tick();
        check("nb5_wrap_to_0", 64'(bank_valid5), 64'b00101);
        check("nb5_err_before_rd", 64'(err5), 0);
        fime_y = 8'd0; fime_x = 8'd0; fime_cur = 9'd3;
        fime_rden5 = 1; tick();
        check("nb5_err_rd_invalid", 64'(err5), 64'b01);
        check("nb5_vld_not_early", 64'(fime_vld5), 0);
        tick();
        check("nb5_vld_latency", 64'(fime_vld5), 1);
        check("nb5_fme_vld_idle", 64'(fme_vld5), 0);
        check("nb5_fme_pel_idle", 64'(|fme_pel5), 0);
        tick();

        fime_rd(5, 12, 0, 0, 16); tick();
        fime_rd(5, 13, 0, 0, 17); tick();
        rstn = 1'b0;
        #1;
        check("midrst_fime_vld", 64'(fime_vld3), 0);
        check("midrst_err3", 64'(err3), 0);
        check("midrst_bank_valid3", 64'(bank_valid3), 0);
        check("midrst_bank_valid5", 64'(bank_valid5), 0);
        check("midrst_err5", 64'(err5), 0);
        exp_fime_q.delete(); due_fime_q.delete();
        exp_fme_q.delete(); due_fme_q.delete();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        check("midrst_no_late_vld", 64'(fime_vld3), 0);
        check("queues_drained", 64'(exp_fime_q.size() + exp_fme_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
